// File: rtl/cmp_sort_ctrl_if.sv
// cmp_sort_ctrl_if: stream bundle for the sorter.
//   Input side : in_valid/in_ready/in_data   (producer -> sorter)
//   Output side: out_valid/out_ready/out_data/out_last (sorter -> consumer)
//   slave  modport: the sorter's view
//   master modport: the producer/consumer (testbench) view
interface cmp_sort_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// simple_comparator: unsigned 4-bit magnitude comparator, one-hot result.
//   a, b       : operands
//   a_greater  : a > b
//   a_equal    : a == b
//   a_less     : a < b
module simple_comparator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       a_greater,
    output logic       a_equal,
    output logic       a_less
);
    assign a_greater = (a > b);
    assign a_equal   = (a == b);
    assign a_less    = (a < b);
endmodule

// cmp_sort_ctrl: loads DEPTH words, bubble-sorts them in place through one
// shared comparator (one compare per cycle, early exit on a swap-free pass),
// then streams them out smallest first.
//   clk, rst_n : clock, async active-low reset (aborts any burst in flight)
//   bus        : slave side of cmp_sort_ctrl_if (input and output streams)
//   busy       : high while sorting or streaming out
//   swap_count : swaps made for the current burst, held until the next burst
// WIDTH must stay 4 to match the comparator; DEPTH may be 2..16.
module cmp_sort_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cmp_sort_ctrl_if.slave     bus,
    output logic               busy,
    output logic [7:0]         swap_count
);
    localparam int IDXW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);
    localparam logic [IDXW-1:0] LAST_J   = IDXW'(DEPTH - 2);

    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [IDXW-1:0]   wr_idx, rd_idx, j, pass;
    logic [IDXW-1:0]   j_nxt;
    logic              swapped;
    logic [WIDTH-1:0]  cmp_a, cmp_b;
    logic              a_gt, a_eq, a_lt;
    logic              do_swap;
    logic              pass_end, sort_done;
    logic              in_fire, out_fire;

    assign j_nxt = j + 1'b1;
    assign cmp_a = mem[j];
    assign cmp_b = mem[j_nxt];

    simple_comparator u_cmp (
        .a         (cmp_a),
        .b         (cmp_b),
        .a_greater (a_gt),
        .a_equal   (a_eq),
        .a_less    (a_lt)
    );

    // Only a strict "greater" swaps, so equal keys keep their order. The
    // result is one-hot; qualifying with the other two flags keeps an
    // inconsistent compare from ever reordering the array.
    assign do_swap   = (state == SORT) && a_gt && !(a_eq || a_lt);
    assign pass_end  = (j == LAST_J);
    // This cycle's swap counts toward "the pass swapped".
    assign sort_done = pass_end && (!(swapped || do_swap) || (pass == LAST_J));

    assign in_fire  = (state == LOAD) && bus.in_valid;
    assign out_fire = (state == OUT)  && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        busy          = 1'b0;
        case (state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && (wr_idx == LAST_IDX)) state_nxt = SORT;
            end
            SORT: begin
                busy = 1'b1;
                if (sort_done) state_nxt = OUT;
            end
            OUT: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_data  = mem[rd_idx];
                bus.out_last  = (rd_idx == LAST_IDX);
                if (bus.out_ready && (rd_idx == LAST_IDX)) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            j          <= '0;
            pass       <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
        end else begin
            if (in_fire) begin
                mem[wr_idx] <= bus.in_data;
                if (wr_idx == LAST_IDX) begin
                    wr_idx     <= '0;
                    swap_count <= '0;
                    j          <= '0;
                    pass       <= '0;
                    swapped    <= 1'b0;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end

            if (state == SORT) begin
                if (do_swap) begin
                    mem[j]     <= cmp_b;
                    mem[j_nxt] <= cmp_a;
                    swap_count <= swap_count + 8'd1;
                end
                if (pass_end) begin
                    j       <= '0;
                    swapped <= 1'b0;
                    if (sort_done) rd_idx <= '0;
                    else           pass   <= pass + 1'b1;
                end else begin
                    j       <= j_nxt;
                    swapped <= swapped || do_swap;
                end
            end

            if (out_fire) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            end
        end
    end
endmodule
